// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Channel state encoding, default timing constants, button indices.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HOLD,
        REPEAT,
        DEB_RELEASE
    } chan_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_RATE     = 10_000_000;
    localparam logic [3:0] DEF_REPEAT_MASK = 4'b0011;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, debounce/auto-repeat FSM and
// its shared counter. pulse is a Mealy output registered by the top.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse,
    output logic held
);

    localparam int MAXP = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    logic [1:0]    sync_q;
    logic          sync;
    chan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          held_q, held_d;

    assign sync = sync_q[1];
    assign held = held_q;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // State, counter and debounced level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    // Next state: debounce both edges, then hold / auto-repeat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        held_d  = held_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sync) state_d = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    held_d  = 1'b1;
                end
            end
            HOLD: begin
                if (!sync) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end else if (!REPEAT_EN) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                end
            end
            REPEAT: begin
                if (!sync) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == RATE_LAST) begin
                    cnt_d = '0;
                end
            end
            DEB_RELEASE: begin
                if (sync) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    // Pulse on accepted press and on each repeat tick.
    always_comb begin
        pulse = 1'b0;
        unique case (state_q)
            DEB_PRESS: pulse = sync && (cnt_q == DEB_LAST);
            HOLD:      pulse = REPEAT_EN && sync && (cnt_q == DELAY_LAST);
            REPEAT:    pulse = sync && (cnt_q == RATE_LAST);
            default:   pulse = 1'b0;
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Four conditioned buttons feeding the write FSM command inputs.
// Opposing pairs cancel; enable masks pulses at the output register.
module button_conditioner
    import button_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int         REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int         REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [3:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] btn_raw,
    output logic       push_up,
    output logic       push_down,
    output logic       push_left,
    output logic       push_right,
    output logic [3:0] held
);

    logic [3:0] pulse;
    logic [3:0] gated;

    for (genvar i = 0; i < 4; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (btn_raw[i]),
            .pulse   (pulse[i]),
            .held    (held[i])
        );
    end

    assign gated = pulse & {4{enable}};

    // Register commands; simultaneous opposite directions cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            push_up    <= 1'b0;
            push_down  <= 1'b0;
            push_left  <= 1'b0;
            push_right <= 1'b0;
        end else begin
            push_up    <= gated[BTN_UP]    & ~gated[BTN_DOWN];
            push_down  <= gated[BTN_DOWN]  & ~gated[BTN_UP];
            push_left  <= gated[BTN_LEFT]  & ~gated[BTN_RIGHT];
            push_right <= gated[BTN_RIGHT] & ~gated[BTN_LEFT];
        end
    end

endmodule
